fetch_entry_queue: RTL and testbench

FETCH_ENTRY_QUEUE -- requirements
Module: fetch_entry_queue

---
 rtl/fetch_entry_queue.sv | 91 +++++++++
 tb/tb_fetch_entry_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_entry_queue.sv
// Fetch entry queue: small in-order FIFO between the fetch frontend and decode.
// Entries are registered before they can reach the head, so there is no
// fall-through path. A pushed exception entry blocks further pushes until a
// flush or reset clears the hold.
module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [VLEN-1:0]            fetch_addr_i,
    input  logic [31:0]                fetch_instr_i,
    input  logic                       fetch_ex_i,
    output logic                       decode_valid_o,
    input  logic                       decode_ready_i,
    output logic [VLEN-1:0]            decode_addr_o,
    output logic [31:0]                decode_instr_o,
    output logic                       decode_ex_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       fault_hold_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [VLEN-1:0] addr;
        logic [31:0]     instr;
        logic            ex;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fault_q, fault_d;
    logic            push, pop;
    entry_t          head;

    // Handshakes: a pending fault, flush or reset closes the input side.
    assign fetch_ready_o  = (count_q < FULL) && !fault_q && !flush_i && !rst_i;
    assign decode_valid_o = (count_q != '0);
    assign push           = fetch_valid_i && fetch_ready_o;
    assign pop            = decode_valid_o && decode_ready_i && !flush_i;

    // Head fields are forced to zero while the queue is empty.
    assign head           = mem_q[rptr_q];
    assign decode_addr_o  = decode_valid_o ? head.addr  : '0;
    assign decode_instr_o = decode_valid_o ? head.instr : '0;
    assign decode_ex_o    = decode_valid_o ? head.ex    : 1'b0;
    assign count_o        = count_q;
    assign fault_hold_o   = fault_q;

    // Next-state for pointers, occupancy and the fault hold.
    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        fault_d = fault_q | (push & fetch_ex_i);
    end

    // Control state; reset and flush both return the queue to empty.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    // Storage write; contents are don't-care until counted as valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= '{addr: fetch_addr_i, instr: fetch_instr_i, ex: fetch_ex_i};
        end
    end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Bench for fetch_entry_queue: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_fetch_entry_queue;
    localparam int DEPTH = 4;
    localparam int VLEN  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst, flush, fv, dr, ex;
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
    logic            fready, dvalid, dex, fault;
    logic [VLEN-1:0] daddr;
    logic [31:0]     dinstr;
    logic [CW-1:0]   count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_entry_queue #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fetch_valid_i(fv), .fetch_ready_o(fready),
        .fetch_addr_i(addr), .fetch_instr_i(instr), .fetch_ex_i(ex),
        .decode_valid_o(dvalid), .decode_ready_i(dr),
        .decode_addr_o(daddr), .decode_instr_o(dinstr), .decode_ex_o(dex),
        .count_o(count), .fault_hold_o(fault)
    );

    // Reference model: plain FIFO of entries plus a sticky fault flag.
    typedef struct {
        logic [VLEN-1:0] addr;
        logic [31:0]     instr;
        logic            ex;
    } ent_t;
    ent_t mq[$];
    bit   mfault;

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && !mfault && !flush && !rst;
    endfunction
    function automatic logic [VLEN-1:0] m_addr();
        return (mq.size() != 0) ? mq[0].addr : '0;
    endfunction
    function automatic logic [31:0] m_instr();
        return (mq.size() != 0) ? mq[0].instr : '0;
    endfunction
    function automatic logic m_ex();
        return (mq.size() != 0) ? mq[0].ex : 1'b0;
    endfunction

    // Advance one clock, updating the model with this cycle's inputs.
    task automatic tick();
        bit do_push, do_pop;
        ent_t e;
        do_push = fv && m_ready();
        do_pop  = (mq.size() != 0) && dr;
        e = '{addr, instr, ex};
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
            mfault = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(e);
                if (e.ex) mfault = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; fv = 0; dr = 0; ex = 0; addr = '0; instr = '0;
    endtask

    task automatic clear();
        idle(); flush = 1; tick(); flush = 0; #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); tick(); #1;
        n_cmp++; if (fready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", fready); end
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (dvalid !== 1'b0 || fault !== 1'b0) begin n_err++; $display("FAIL reset_flags dvalid=%b fault=%b exp=0/0", dvalid, fault); end
        n_cmp++; if (daddr !== '0 || dinstr !== '0 || dex !== 1'b0) begin n_err++; $display("FAIL reset_data addr=%h instr=%h ex=%b exp=0", daddr, dinstr, dex); end
        rst = 0; #1;
        n_cmp++; if (fready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready got=%b exp=1", fready); end
    endtask

    task automatic test_single();
        clear();
        fv = 1; addr = 64'h1000; instr = 32'h0000_0013; #1;
        n_cmp++; if (dvalid !== 1'b0) begin n_err++; $display("FAIL single_nofallthru dvalid=%b exp=0", dvalid); end
        tick(); fv = 0; #1;
        n_cmp++; if (dvalid !== 1'b1 || daddr !== 64'h1000 || dinstr !== 32'h13) begin n_err++; $display("FAIL single_head v=%b addr=%h instr=%h exp=1/1000/13", dvalid, daddr, dinstr); end
        n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL single_count got=%0d exp=1", count); end
    endtask

    task automatic test_full();
        clear();
        for (int i = 0; i < DEPTH; i++) begin
            fv = 1; addr = 64'h2000 + 64'(i * 4); instr = 32'hA000_0000 + i; tick();
        end
        n_cmp++; if (count !== CW'(DEPTH) || fready !== 1'b0) begin n_err++; $display("FAIL full_state count=%0d ready=%b exp=4/0", count, fready); end
        dr = 1; addr = 64'h3000; #1;
        n_cmp++; if (fready !== 1'b0) begin n_err++; $display("FAIL full_ready_with_pop got=%b exp=0", fready); end
        tick(); fv = 0; dr = 0; #1;
        n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL full_after_pop count=%0d exp=3", count); end
        n_cmp++; if (daddr !== 64'h2004) begin n_err++; $display("FAIL full_head addr=%h exp=2004", daddr); end
    endtask

    task automatic test_wrap();
        int seen;
        logic [VLEN-1:0] exp_a;
        clear();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            fv = (i < 6); ex = 0; dr = 1;
            addr = 64'h4000 + 64'(i * 4); instr = $urandom; #1;
            if (dvalid) begin
                exp_a = 64'h4000 + 64'(seen * 4);
                n_cmp++; if (daddr !== exp_a || dinstr !== m_instr()) begin n_err++; $display("FAIL wrap_order addr=%h exp=%h", daddr, exp_a); end
                seen++;
            end
            n_cmp++; if (count > CW'(DEPTH)) begin n_err++; $display("FAIL wrap_count got=%0d exp<=4", count); end
            tick();
        end
        idle(); #1;
        n_cmp++; if (seen !== 6 || count !== '0) begin n_err++; $display("FAIL wrap_total popped=%0d count=%0d exp=6/0", seen, count); end
    endtask

    task automatic test_fault();
        clear();
        fv = 1; ex = 1; addr = 64'h5000; instr = 32'h1; tick();
        ex = 0; addr = 64'h5004; #1;
        n_cmp++; if (fault !== 1'b1 || fready !== 1'b0) begin n_err++; $display("FAIL fault_hold fault=%b ready=%b exp=1/0", fault, fready); end
        tick(); addr = 64'h5008; tick(); #1;
        n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL fault_blocked count=%0d exp=1", count); end
        dr = 1; #1;
        n_cmp++; if (dvalid !== 1'b1 || dex !== 1'b1 || daddr !== 64'h5000) begin n_err++; $display("FAIL fault_pop v=%b ex=%b addr=%h exp=1/1/5000", dvalid, dex, daddr); end
        tick(); dr = 0; #1;
        n_cmp++; if (fault !== 1'b1 || count !== '0) begin n_err++; $display("FAIL fault_sticky fault=%b count=%0d exp=1/0", fault, count); end
        flush = 1; tick(); flush = 0; #1;
        n_cmp++; if (fault !== 1'b0 || fready !== 1'b1) begin n_err++; $display("FAIL fault_flush fault=%b ready=%b exp=0/1", fault, fready); end
        fv = 0;
    endtask

    task automatic test_flush();
        clear();
        for (int i = 0; i < 3; i++) begin fv = 1; addr = 64'h6000 + 64'(i); instr = i; tick(); end
        fv = 1; dr = 1; flush = 1; addr = 64'h6FFF; tick();
        flush = 0; fv = 0; dr = 0; #1;
        n_cmp++; if (count !== '0 || dvalid !== 1'b0) begin n_err++; $display("FAIL flush_empty count=%0d v=%b exp=0/0", count, dvalid); end
        fv = 1; addr = 64'h7000; tick(); addr = 64'h7004; tick(); fv = 0; dr = 1; #1;
        n_cmp++; if (daddr !== 64'h7000 || count !== CW'(2)) begin n_err++; $display("FAIL flush_after0 addr=%h count=%0d exp=7000/2", daddr, count); end
        tick(); #1;
        n_cmp++; if (daddr !== 64'h7004) begin n_err++; $display("FAIL flush_after1 addr=%h exp=7004", daddr); end
        tick(); dr = 0; #1;
        n_cmp++; if (count !== '0 || dvalid !== 1'b0) begin n_err++; $display("FAIL flush_nodup count=%0d v=%b exp=0/0", count, dvalid); end
    endtask

    task automatic test_reset_mid();
        clear();
        fv = 1; addr = 64'h8000; tick(); addr = 64'h8004; tick();
        fv = 0; dr = 1; rst = 1; tick();
        rst = 0; dr = 0; #1;
        n_cmp++; if (count !== '0 || dvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_empty count=%0d v=%b exp=0/0", count, dvalid); end
        n_cmp++; if (fready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", fready); end
    endtask

    task automatic test_random();
        clear();
        for (int i = 0; i < 400; i++) begin
            fv    = ($urandom_range(0, 9) < 7);
            dr    = ($urandom_range(0, 9) < 6);
            ex    = ($urandom_range(0, 19) == 0);
            flush = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            addr  = {$urandom, $urandom};
            instr = $urandom;
            #1;
            n_cmp++; if (fready !== m_ready()) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, fready, m_ready()); end
            n_cmp++; if (count !== CW'(mq.size()) || dvalid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_count cyc=%0d got=%0d/%b exp=%0d", i, count, dvalid, mq.size()); end
            n_cmp++; if (daddr !== m_addr() || dinstr !== m_instr() || dex !== m_ex()) begin n_err++; $display("FAIL rand_head cyc=%0d got=%h/%h/%b exp=%h/%h/%b", i, daddr, dinstr, dex, m_addr(), m_instr(), m_ex()); end
            n_cmp++; if (fault !== mfault) begin n_err++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", i, fault, mfault); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        mfault = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_full();
        test_wrap();
        test_fault();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
